// File: rtl/csa_multiword_seq.sv
// ---------------------------------------------------------------------------
// csa_multiword_seq
//
// Wide add/subtract built from a single SLICE-bit carry-skip adder slice.
// The slice is reused once per cycle, least-significant slice first, and the
// carry between slices is held in a register. Operands arrive over a
// valid/ready handshake. The result is held on a valid/ready handshake until
// the consumer takes it.
//
// Optional feature (compile-time macro CSA_SEQ_OVERLAP_EN):
//   When this macro is defined, a new operation can be accepted in the same
//   cycle as the output handshake. The FSM then goes straight from DONE to
//   RUN. This removes the IDLE bubble, so throughput is one operation every
//   N+1 cycles instead of every N+2.
//
// Parameters:
//   WIDTH  operand/result width; must be a multiple of SLICE
//   SLICE  bits added per cycle (width of the internal adder)
//   SKIP   skip-group size of the internal adder; must divide SLICE
//   The slice count N = WIDTH/SLICE must be at least 2.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand request
//   in_ready   sequencer can accept operands
//   op_a       operand A
//   op_b       operand B
//   sub        1 = A-B, 0 = A+B+cin
//   cin        carry-in for add; ignored when sub=1
//   out_valid  result available
//   out_ready  consumer takes result
//   result     sum/difference, modulo 2^WIDTH
//   cout       carry out of the MSB (for subtract: 1 = no borrow)
//   ovf        two's-complement signed overflow
//   busy       high in RUN or DONE
// ---------------------------------------------------------------------------
module csa_multiword_seq #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16,
  parameter int SKIP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = WIDTH / SLICE;
  localparam int NG = SLICE / SKIP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Carry-skip slice. Each SKIP-bit group ripples internally. When every bit
  // of a group propagates, the group carry-in bypasses the ripple chain and
  // drives the group carry-out directly. The function returns {cout, sum}.
  // -------------------------------------------------------------------------
  function automatic logic [SLICE:0] csa_slice(
    input logic [SLICE-1:0] a,
    input logic [SLICE-1:0] b,
    input logic             ci
  );
    logic [SLICE-1:0] p;
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] s;
    logic             gc;
    logic             rc;
    logic             gp;
    p  = a ^ b;
    g  = a & b;
    s  = '0;
    gc = ci;
    for (int grp = 0; grp < NG; grp++) begin
      rc = gc;
      gp = 1'b1;
      for (int i = 0; i < SKIP; i++) begin
        s[grp*SKIP+i] = p[grp*SKIP+i] ^ rc;
        rc            = g[grp*SKIP+i] | (p[grp*SKIP+i] & rc);
        gp            = gp & p[grp*SKIP+i];
      end
      gc = gp ? gc : rc;
    end
    return {gc, s};
  endfunction

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;       // already inverted for subtract
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;

  // -------------------------------------------------------------------------
  // Combinational signals
  // -------------------------------------------------------------------------
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;
  logic [SLICE-1:0] w_a_slice;
  logic [SLICE-1:0] w_b_slice;
  logic [SLICE:0]   w_slice_out;
  logic [SLICE-1:0] w_sum;
  logic             w_slice_cout;

  assign w_a_slice    = r_a[int'(r_cnt)*SLICE +: SLICE];
  assign w_b_slice    = r_b[int'(r_cnt)*SLICE +: SLICE];
  assign w_slice_out  = csa_slice(w_a_slice, w_b_slice, r_carry);
  assign w_sum        = w_slice_out[SLICE-1:0];
  assign w_slice_cout = w_slice_out[SLICE];
  assign w_last       = (r_cnt == CW'(N - 1));
  assign w_accept     = in_valid && in_ready;

  // -------------------------------------------------------------------------
  // Next-state and handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;

    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (w_accept) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
`ifdef CSA_SEQ_OVERLAP_EN
        in_ready  = out_ready;
`endif
        if (out_ready) w_state_nxt = w_accept ? S_RUN : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        busy        = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequential state and datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments, so every register
    // in this block samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        // For subtract, A-B is computed as A + ~B + 1.
        r_a     <= op_a;
        r_b     <= sub ? ~op_b : op_b;
        r_carry <= sub | cin;
        r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        r_result[int'(r_cnt)*SLICE +: SLICE] <= w_sum;
        r_carry                              <= w_slice_cout;
        if (w_last) begin
          r_cnt  <= '0;
          r_cout <= w_slice_cout;
          // The top slice holds the sign bits of A, B' and the sum.
          r_ovf  <= (w_a_slice[SLICE-1] == w_b_slice[SLICE-1]) &&
                    (w_sum[SLICE-1] != w_a_slice[SLICE-1]);
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_csa_multiword_seq.sv
// ---------------------------------------------------------------------------
// tb_csa_multiword_seq
//
// Scoreboard bench for csa_multiword_seq at its default sizing (64/16/4).
// The driver pushes a hand-computed expectation when it issues each
// operation. A separate monitor checks latency when out_valid rises and
// compares result/cout/ovf on every output handshake.
// ---------------------------------------------------------------------------
module tb_csa_multiword_seq;

  localparam int WIDTH = 64;
  localparam int SLICE = 16;
  localparam int N     = WIDTH / SLICE;
`ifdef CSA_SEQ_OVERLAP_EN
  localparam int GAP   = N + 1;
`else
  localparam int GAP   = N + 2;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             busy;

  csa_multiword_seq #(.WIDTH(WIDTH), .SLICE(SLICE), .SKIP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter; every sample taken between two rising edges sees one value.
  int pcnt = 0;
  always @(posedge clk) pcnt++;

  typedef struct {
    logic [63:0] res;
    logic        co;
    logic        ov;
    int          acc;
  } exp_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
    logic        c;
    logic [63:0] er;
    logic        eco;
    logic        eov;
  } vec_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // -------------------------------------------------------------------------
  // Monitor
  // -------------------------------------------------------------------------
  logic prev_ov = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (q.size() > 0) check("latency", 64'(pcnt - q[0].acc), 64'(N + 1));
        else              check("spurious out_valid", 64'(out_valid), 64'(0));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected handshake", 64'(out_valid), 64'(0));
        end else begin
          mon_e = q.pop_front();
          check("result", result, mon_e.res);
          check("cout", 64'(cout), 64'(mon_e.co));
          check("ovf", 64'(ovf), 64'(mon_e.ov));
        end
      end
      prev_ov = out_valid;
    end
  end

  // -------------------------------------------------------------------------
  // Driver helpers. The driver always sits at posedge+1.
  // -------------------------------------------------------------------------
  task automatic send(input logic [63:0] a, input logic [63:0] b,
                      input logic s, input logic c, input logic push,
                      input logic [63:0] er, input logic eco, input logic eov,
                      output int acc);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    acc = pcnt;
    if (!in_ready) begin
      check("in_ready timeout", 64'(in_ready), 64'(1));
      return;
    end
    op_a = a; op_b = b; sub = s; cin = c; in_valid = 1'b1;
    if (push) q.push_back('{er, eco, eov, pcnt});
    @(posedge clk); #1;
    // Scramble inputs after the accept; the registered operands must hold.
    in_valid = 1'b0; op_a = '1; op_b = '1; sub = ~s; cin = ~c;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("scoreboard drained", 64'(q.size()), 64'(0));
  endtask

  vec_t vecs [9] = '{
    '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0},
    '{64'h0, 64'h1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0},
    '{64'h5, 64'h3, 1'b1, 1'b0, 64'h2, 1'b1, 1'b0},
    '{64'h5, 64'h3, 1'b1, 1'b1, 64'h2, 1'b1, 1'b0},
    '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1},
    '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b1, 64'h0000_0000_0001_0001, 1'b0, 1'b0},
    '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1},
    '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0},
    '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1}
  };

  localparam logic [63:0] BP_A   = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] BP_B   = 64'h0FED_CBA9_8765_4321;
  localparam logic [63:0] BP_SUM = 64'h2222_2222_2222_2211;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int acc0;
    int acc1;
    int t;
    rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0;
    sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset result", result, 64'(0));
    check("reset cout", 64'(cout), 64'(0));
    check("reset ovf", 64'(ovf), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready after reset", 64'(in_ready), 64'(1));

    // Directed vectors, one at a time
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, 1'b1,
           vecs[i].er, vecs[i].eco, vecs[i].eov, acc0);
      drain();
    end

    // Backpressure with ignored requests during RUN
    out_ready = 1'b0;
    send(BP_A, BP_B, 1'b0, 1'b0, 1'b1, BP_SUM, 1'b0, 1'b0, acc0);
    @(posedge clk); #1;
    in_valid = 1'b1; op_a = 64'h1; op_b = 64'h1; sub = 1'b0; cin = 1'b0;
    check("in_ready in RUN", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp out_valid", 64'(out_valid), 64'(1));
      check("bp in_ready", 64'(in_ready), 64'(0));
      check("bp result", result, BP_SUM);
      check("bp cout", 64'(cout), 64'(0));
      check("bp ovf", 64'(ovf), 64'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle after handshake out_valid", 64'(out_valid), 64'(0));
    check("idle after handshake busy", 64'(busy), 64'(0));
    check("result retained", result, BP_SUM);
    check("scoreboard after bp", 64'(q.size()), 64'(0));

    // Reset in the middle of RUN (k=2)
    send(64'h1111_2222_3333_4444, 64'h1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, acc0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrun reset out_valid", 64'(out_valid), 64'(0));
    check("midrun reset result", result, 64'(0));
    check("midrun reset busy", 64'(busy), 64'(0));
    check("midrun reset cout", 64'(cout), 64'(0));
    rst_n = 1'b1;
    check("in_ready after midrun reset", 64'(in_ready), 64'(1));
    send(64'h3, 64'h4, 1'b0, 1'b0, 1'b1, 64'h7, 1'b0, 1'b0, acc0);
    drain();

    // Back-to-back throughput
    send(64'h1, 64'h2, 1'b0, 1'b0, 1'b1, 64'h3, 1'b0, 1'b0, acc0);
    send(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b1,
         64'h0000_0002_0000_0000, 1'b0, 1'b0, acc1);
    check("throughput gap", 64'(acc1 - acc0), 64'(GAP));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
